// File: rtl/prog_toggle_counter_pkg.sv
// ---------------------------------------------------------------------------
// prog_toggle_counter_pkg
// Purpose : shared end-mode encodings for the programmable toggle counter.
// Contents: MODE_WRAP / MODE_SAT / MODE_ONESHOT / MODE_RSVD (2-bit mode codes).
// ---------------------------------------------------------------------------
package prog_toggle_counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'd0;
   localparam logic [1:0] MODE_SAT     = 2'd1;
   localparam logic [1:0] MODE_ONESHOT = 2'd2;
   localparam logic [1:0] MODE_RSVD    = 2'd3;   // treated exactly like WRAP

endpackage

// File: rtl/prog_toggle_counter_toggle_reg.sv
// ---------------------------------------------------------------------------
// prog_toggle_counter_toggle_reg  (the toggle_reg sub-block)
// Purpose : single toggle flop with synchronous active-high reset.
// Ports   : i_clock      in  1  rising-edge clock
//           i_reset      in  1  synchronous reset, forces o_q to 0
//           i_toggle_en  in  1  invert the stored bit on this edge
//           o_q          out 1  registered toggle state
// ---------------------------------------------------------------------------
module prog_toggle_counter_toggle_reg (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_toggle_en,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_q <= 1'b0;
      end else if (i_toggle_en) begin
         r_q <= ~r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/prog_toggle_counter.sv
// ---------------------------------------------------------------------------
// prog_toggle_counter
// Purpose : programmable up/down counter bounded by a runtime max value, with
//           WRAP / SAT / ONESHOT end modes, a one-cycle terminal-count pulse
//           and a toggle output that flips on every wrap, giving a
//           divide-by-2*(max+1) enable source.
// Ports   : i_clock       in  1      rising-edge clock
//           i_reset       in  1      synchronous active-high reset (top priority)
//           i_enable      in  1      advance one step
//           i_load        in  1      load count (beats enable)
//           i_load_value  in  WIDTH  load value, clamped to i_max_value
//           i_max_value   in  WIDTH  upper bound, sampled every edge
//           i_up_down     in  1      1 = up, 0 = down
//           i_mode        in  2      0 WRAP, 1 SAT, 2 ONESHOT, 3 as WRAP
//           o_count       out WIDTH  registered count
//           o_tc          out 1      registered terminal-count pulse
//           o_toggle_out  out 1      flips on each WRAP terminal event
//           o_done        out 1      ONESHOT finished, held until load/reset
// ---------------------------------------------------------------------------
module prog_toggle_counter
   import prog_toggle_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic [WIDTH-1:0] i_max_value,
   input  logic             i_up_down,
   input  logic [1:0]       i_mode,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
   output logic             o_toggle_out,
   output logic             o_done
);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_done;
   logic             r_sat_hit;

   logic             w_terminal;
   logic             w_wrap_mode;
   logic             w_oneshot_locked;
   logic             w_wrap_event;

   function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v,
                                                     input logic [WIDTH-1:0] m);
      return (v > m) ? m : v;
   endfunction

   // Up uses >= so a max lowered below the current count still terminates.
   assign w_terminal       = i_up_down ? (r_count >= i_max_value) : (r_count == '0);
   assign w_wrap_mode      = (i_mode == MODE_WRAP) || (i_mode == MODE_RSVD);
   assign w_oneshot_locked = (i_mode == MODE_ONESHOT) && r_done;
   assign w_wrap_event     = i_enable && !i_load && w_terminal && w_wrap_mode;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count   <= '0;
         r_tc      <= 1'b0;
         r_done    <= 1'b0;
         r_sat_hit <= 1'b0;
      end else if (i_load) begin
         r_count   <= clamp_to_max(i_load_value, i_max_value);
         r_tc      <= 1'b0;
         r_done    <= 1'b0;
         r_sat_hit <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         // sat_hit only matters in SAT; clearing it whenever another mode is
         // seen means re-entering SAT always starts with a fresh pulse.
         if (i_mode != MODE_SAT) begin
            r_sat_hit <= 1'b0;
         end
         if (i_enable && !w_oneshot_locked) begin
            if (!w_terminal) begin
               r_count   <= i_up_down ? (r_count + 1'b1) : (r_count - 1'b1);
               r_sat_hit <= 1'b0;
            end else begin
               case (i_mode)
                  MODE_SAT: begin
                     r_tc      <= ~r_sat_hit;
                     r_sat_hit <= 1'b1;
                  end
                  MODE_ONESHOT: begin
                     r_tc   <= 1'b1;
                     r_done <= 1'b1;
                  end
                  default: begin
                     r_count <= i_up_down ? '0 : i_max_value;
                     r_tc    <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

   prog_toggle_counter_toggle_reg u_toggle_reg (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_toggle_en (w_wrap_event),
      .o_q         (o_toggle_out)
   );

   assign o_count = r_count;
   assign o_tc    = r_tc;
   assign o_done  = r_done;

endmodule

// File: tb/tb_prog_toggle_counter.sv
// ---------------------------------------------------------------------------
// tb_prog_toggle_counter
// Purpose : scoreboard bench for prog_toggle_counter (WIDTH=4). A stimulus
//           process drives inputs on the falling edge and pushes the expected
//           post-edge outputs from a behavioural model; a monitor pops and
//           compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_prog_toggle_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         ld = 1'b0;
   logic [W-1:0] lv = '0;
   logic [W-1:0] mx = '0;
   logic         ud = 1'b1;
   logic [1:0]   md = 2'd0;
   logic [W-1:0] count;
   logic         tc;
   logic         tog;
   logic         done;

   always #5 clk = ~clk;

   prog_toggle_counter #(.WIDTH(W)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_enable     (en),
      .i_load       (ld),
      .i_load_value (lv),
      .i_max_value  (mx),
      .i_up_down    (ud),
      .i_mode       (md),
      .o_count      (count),
      .o_tc         (tc),
      .o_toggle_out (tog),
      .o_done       (done)
   );

   typedef struct {
      int count;
      int tc;
      int tog;
      int done;
      bit en_at_edge;
      int step_no;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_errors = 0;
   int n_steps  = 0;

   // Reference model state, kept as plain integers.
   int  m_count    = 0;
   int  m_wraps    = 0;   // toggle_out is the parity of wraps since reset
   bit  m_done     = 0;
   bit  m_sat_hit  = 0;
   int  m_prev_md  = 0;

   task automatic check(input string nm, input int got, input int want, input int stp);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s step=%0d got=%0d expected=%0d", nm, stp, got, want);
      end
   endtask

   // Apply the rules for one rising edge; returns the expected tc.
   function automatic int model_edge(input bit r, input bit l, input bit e, input bit up,
                                     input int mode, input int lval, input int mval);
      int  t;
      bit  term;
      t = 0;
      if (r) begin
         m_count = 0; m_wraps = 0; m_done = 0; m_sat_hit = 0;
      end else if (l) begin
         m_count   = (lval < mval) ? lval : mval;
         m_done    = 0;
         m_sat_hit = 0;
      end else begin
         if (mode != m_prev_md) m_sat_hit = 0;
         if (e && !(mode == 2 && m_done)) begin
            term = up ? (m_count >= mval) : (m_count == 0);
            if (!term) begin
               m_count   = up ? m_count + 1 : m_count - 1;
               m_sat_hit = 0;
            end else if (mode == 1) begin
               t = m_sat_hit ? 0 : 1;
               m_sat_hit = 1;
            end else if (mode == 2) begin
               t = 1;
               m_done = 1;
            end else begin
               m_count = up ? 0 : mval;
               m_wraps++;
               t = 1;
            end
         end
      end
      m_prev_md = mode;
      return t;
   endfunction

   task automatic step(input bit r, input bit l, input bit e, input bit up,
                       input int mode, input int lval, input int mval);
      exp_t x;
      int   t;
      @(negedge clk);
      rst = r; ld = l; en = e; ud = up;
      md = mode[1:0]; lv = lval[W-1:0]; mx = mval[W-1:0];
      t = model_edge(r, l, e, up, mode, lval, mval);
      n_steps++;
      x.count = m_count;
      x.tc = t;
      x.tog = m_wraps % 2;
      x.done = int'(m_done);
      x.en_at_edge = e && !r;
      x.step_no = n_steps;
      sb.push_back(x);
   endtask

   // Monitor: one expectation per rising edge, sampled 1 time unit later.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check("count", int'(count), x.count, x.step_no);
         check("tc", int'(tc), x.tc, x.step_no);
         check("toggle_out", int'(tog), x.tog, x.step_no);
         check("done", int'(done), x.done, x.step_no);
         if (!x.en_at_edge) check("tc_without_enable", int'(tc), 0, x.step_no);
      end
   end

   initial begin
      int mode_r, max_r, up_r;
      // 1: reset 2 clk, WRAP up max=5
      step(1, 0, 0, 1, 0, 0, 5);
      step(1, 0, 0, 1, 0, 0, 5);
      repeat (13) step(0, 0, 1, 1, 0, 0, 5);
      // 2: WRAP down max=3, load 2 then enable
      step(0, 1, 0, 0, 0, 2, 3);
      repeat (5) step(0, 0, 1, 0, 0, 2, 3);
      // 3: SAT up max=4 from 0, enable 8 clk
      step(0, 1, 0, 1, 1, 0, 4);
      repeat (8) step(0, 0, 1, 1, 1, 0, 4);
      // 4: ONESHOT up max=2, enable held, then load 1 and resume
      step(0, 1, 0, 1, 2, 0, 2);
      repeat (5) step(0, 0, 1, 1, 2, 0, 2);
      step(0, 1, 1, 1, 2, 1, 2);
      repeat (3) step(0, 0, 1, 1, 2, 1, 2);
      // 5: load and enable together, load_value clamped; then hold
      step(0, 1, 1, 1, 0, 9, 6);
      repeat (3) step(0, 0, 0, 1, 0, 9, 6);
      // max_value==0 in WRAP: tc and toggle every enabled cycle
      repeat (4) step(0, 0, 1, 1, 0, 0, 0);
      // 6: reset with count=3, toggle=1, load and enable asserted
      step(1, 0, 0, 1, 0, 0, 3);
      step(0, 1, 0, 1, 0, 0, 3);
      repeat (7) step(0, 0, 1, 1, 0, 0, 3);
      step(1, 1, 1, 1, 0, 2, 3);
      step(0, 0, 0, 1, 0, 2, 3);
      // randomized phase
      mode_r = 0; max_r = 5; up_r = 1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) mode_r = int'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) max_r  = int'($urandom_range(0, 15));
         if ($urandom_range(0, 11) == 0) up_r   = int'($urandom_range(0, 1));
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0),
              up_r[0], mode_r, int'($urandom_range(0, 15)), max_r);
      end
      step(0, 0, 0, 1, 0, 0, 5);
      // drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
      #2;
      check("scoreboard_drained", sb.size(), 0, n_steps);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
